// File: rtl/alu_issue_scheduler.sv
// Four-entry age-ordered ALU issue queue with tag wakeup, oldest-ready select
// and a single valid/ready issue register in front of the ALU.
module alu_issue_scheduler #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_enqValid,
  output logic        o_enqReady,
  input  logic [3:0]  i_enqControl_4,
  input  logic [3:0]  i_enqTag_4,
  input  logic [4:0]  i_enqAreg_5,
  input  logic        i_enqSrc1Rdy,
  input  logic        i_enqSrc2Rdy,
  input  logic [3:0]  i_enqSrc1Tag_4,
  input  logic [3:0]  i_enqSrc2Tag_4,
  input  logic [31:0] i_enqOp1_32,
  input  logic [31:0] i_enqOp2_32,
  input  logic        i_wakeValid,
  input  logic [3:0]  i_wakeTag_4,
  input  logic [31:0] i_wakeData_32,
  output logic        o_issueValid,
  input  logic        i_issueReady,
  output logic [3:0]  o_issueControl_4,
  output logic [3:0]  o_issueTag_4,
  output logic [31:0] o_issueOp1_32,
  output logic [31:0] o_issueOp2_32,
  output logic [4:0]  o_issueAreg_5,
  output logic [2:0]  o_count_3
);
  localparam int IDXW = $clog2(ENTRIES);

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [3:0]  tag;
    logic [4:0]  areg;
    logic        s1_rdy;
    logic [3:0]  s1_tag;
    logic [31:0] op1;
    logic        s2_rdy;
    logic [3:0]  s2_tag;
    logic [31:0] op2;
  } entry_t;

  entry_t [ENTRIES-1:0] ent_q, ent_d;
  entry_t               iss_q, iss_d, enq_ent;
  logic                 iss_vld_q, iss_vld_d;
  logic [2:0]           count_q, count_d, enq_pos;
  logic                 sel_hit, sel_fire, enq_fire;
  logic [IDXW-1:0]      sel_idx;

  function automatic entry_t wake(entry_t e, logic v, logic [3:0] t, logic [31:0] d);
    entry_t r = e;
    if (v && !r.s1_rdy && r.s1_tag == t) begin r.s1_rdy = 1'b1; r.op1 = d; end
    if (v && !r.s2_rdy && r.s2_tag == t) begin r.s2_rdy = 1'b1; r.op2 = d; end
    return r;
  endfunction

  assign o_enqReady = (count_q < 3'(ENTRIES)) && !i_flush;
  assign enq_fire   = i_enqValid && o_enqReady;

  // Select looks only at registered readiness, so a wakeup never issues on its own edge.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (3'(i) < count_q && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel_hit = 1'b1;
        sel_idx = IDXW'(i);
      end
    end
  end

  assign sel_fire = sel_hit && (!iss_vld_q || i_issueReady);
  assign enq_pos  = count_q - 3'(sel_fire);

  always_comb begin
    enq_ent = '{ctrl: i_enqControl_4, tag: i_enqTag_4, areg: i_enqAreg_5,
                s1_rdy: i_enqSrc1Rdy, s1_tag: i_enqSrc1Tag_4, op1: i_enqOp1_32,
                s2_rdy: i_enqSrc2Rdy, s2_tag: i_enqSrc2Tag_4, op2: i_enqOp2_32};
    ent_d = ent_q;
    if (sel_fire) begin
      for (int j = 0; j < ENTRIES-1; j++)
        if (IDXW'(j) >= sel_idx) ent_d[j] = ent_q[j+1];
      ent_d[ENTRIES-1] = '0;
    end
    for (int j = 0; j < ENTRIES; j++)
      ent_d[j] = wake(ent_d[j], i_wakeValid, i_wakeTag_4, i_wakeData_32);
    if (enq_fire)
      ent_d[enq_pos[IDXW-1:0]] = wake(enq_ent, i_wakeValid, i_wakeTag_4, i_wakeData_32);
    count_d = count_q + 3'(enq_fire) - 3'(sel_fire);
  end

  always_comb begin
    iss_d     = iss_q;
    iss_vld_d = iss_vld_q;
    if (sel_fire) begin
      iss_d     = ent_q[sel_idx];
      iss_vld_d = 1'b1;
    end else if (iss_vld_q && i_issueReady) begin
      iss_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q     <= '0;
      count_q   <= '0;
      iss_q     <= '0;
      iss_vld_q <= 1'b0;
    end else if (i_flush) begin
      ent_q     <= '0;
      count_q   <= '0;
      iss_vld_q <= 1'b0;
    end else begin
      ent_q     <= ent_d;
      count_q   <= count_d;
      iss_q     <= iss_d;
      iss_vld_q <= iss_vld_d;
    end
  end

  assign o_issueValid     = iss_vld_q;
  assign o_issueControl_4 = iss_q.ctrl;
  assign o_issueTag_4     = iss_q.tag;
  assign o_issueOp1_32    = iss_q.op1;
  assign o_issueOp2_32    = iss_q.op2;
  assign o_issueAreg_5    = iss_q.areg;
  assign o_count_3        = count_q;
endmodule
